conv_tree_deserializer_16: RTL and testbench

CONV_TREE_DESERIALIZER_16 -- requirements
Module: conv_tree_deserializer_16

---
 rtl/conv_tree_deserializer_16.sv | 118 +++++++++++
 tb/tb_conv_tree_deserializer_16.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_tree_deserializer_16.sv
// Serial-to-parallel deserializer with sync-word alignment, gap-limited lock
// and a saturating lock-loss counter. LSB-first, one bit per clock.
module conv_tree_deserializer_16 #(
  parameter int          OUTPUTS_NUM = 16,
  parameter logic [15:0] SYNC_WORD   = 16'hB38F,
  parameter int          MAX_GAP     = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SERIAL_IN,
  input  logic                   REALIGN,
  output logic [OUTPUTS_NUM-1:0] PAR_OUT,
  output logic                   PAR_VALID,
  output logic                   LOCKED,
  output logic                   SYNC_DET,
  output logic [7:0]             LOSS_CNT
);

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } state_t;

  localparam logic [7:0] MAX_GAP_C = 8'(MAX_GAP);

  state_t                 state_q;
  logic [OUTPUTS_NUM-1:0] sr_q;
  logic [OUTPUTS_NUM-1:0] sr_d;
  logic [3:0]             bitcnt_q;
  logic [7:0]             gapcnt_q;
  logic [OUTPUTS_NUM-1:0] par_out_q;
  logic                   par_valid_q;
  logic                   locked_q;
  logic                   sync_det_q;
  logic [7:0]             loss_cnt_q;
  logic                   sync_hit_d;
  logic                   word_end_d;

  // Post-shift view of the stream; all matching is done on this value.
  always_comb begin
    sr_d       = {SERIAL_IN, sr_q[OUTPUTS_NUM-1:1]};
    sync_hit_d = (sr_d == SYNC_WORD);
    word_end_d = (bitcnt_q == 4'd15);
  end

  // Alignment FSM, shift register, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bitcnt_q    <= 4'd0;
      gapcnt_q    <= 8'd0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_det_q  <= 1'b0;
      loss_cnt_q  <= 8'd0;
    end else begin
      sr_q        <= sr_d;
      par_valid_q <= 1'b0;
      sync_det_q  <= 1'b0;
      if (REALIGN) begin
        // Re-hunt on request: no strobes this edge and no loss counted.
        state_q  <= HUNT;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          HUNT: begin
            if (sync_hit_d) begin
              state_q    <= ALIGNED;
              locked_q   <= 1'b1;
              bitcnt_q   <= 4'd0;
              gapcnt_q   <= 8'd0;
              sync_det_q <= 1'b1;
            end else begin
              locked_q <= 1'b0;
            end
          end
          ALIGNED: begin
            bitcnt_q <= bitcnt_q + 4'd1;
            // Only the word boundary is compared; mid-word patterns are ignored.
            if (word_end_d) begin
              if (sync_hit_d) begin
                sync_det_q <= 1'b1;
                gapcnt_q   <= 8'd0;
              end else if (gapcnt_q < MAX_GAP_C) begin
                par_out_q   <= sr_d;
                par_valid_q <= 1'b1;
                gapcnt_q    <= gapcnt_q + 8'd1;
              end else begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                if (loss_cnt_q != 8'hFF) begin
                  loss_cnt_q <= loss_cnt_q + 8'd1;
                end else begin
                  loss_cnt_q <= loss_cnt_q;
                end
              end
            end else begin
              gapcnt_q <= gapcnt_q;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PAR_OUT   = par_out_q;
  assign PAR_VALID = par_valid_q;
  assign LOCKED    = locked_q;
  assign SYNC_DET  = sync_det_q;
  assign LOSS_CNT  = loss_cnt_q;

endmodule

// File: tb/tb_conv_tree_deserializer_16.sv
// Directed bench for conv_tree_deserializer_16 with hand-computed expectations.
module tb_conv_tree_deserializer_16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        SERIAL_IN = 1'b0;
  logic        REALIGN = 1'b0;
  logic [15:0] PAR_OUT;
  logic        PAR_VALID;
  logic        LOCKED;
  logic        SYNC_DET;
  logic [7:0]  LOSS_CNT;

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0;
  int sd_cnt = 0;
  int overlap_cnt = 0;

  localparam logic [15:0] SYNC = 16'hB38F;

  conv_tree_deserializer_16 dut (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .REALIGN(REALIGN),
    .PAR_OUT(PAR_OUT), .PAR_VALID(PAR_VALID), .LOCKED(LOCKED),
    .SYNC_DET(SYNC_DET), .LOSS_CNT(LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let one edge pass, then sample strobes 1 time unit later.
  task automatic send_bit(input logic b);
    SERIAL_IN = b;
    @(posedge CLK);
    #1;
    if (PAR_VALID) pv_cnt++;
    if (SYNC_DET) sd_cnt++;
    if (PAR_VALID && SYNC_DET) overlap_cnt++;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
    RESET = 1'b0;
    pv_cnt = 0;
    sd_cnt = 0;
  endtask

  initial begin
    logic [15:0] w;
    logic [4:0]  pre;

    // Reset state
    do_reset();
    chk("rst_par_out", PAR_OUT, 16'h0000);
    chk("rst_par_valid", {15'd0, PAR_VALID}, 16'd0);
    chk("rst_locked", {15'd0, LOCKED}, 16'd0);
    chk("rst_sync_det", {15'd0, SYNC_DET}, 16'd0);
    chk("rst_loss", {8'd0, LOSS_CNT}, 16'd0);

    // basic
    send_word(SYNC);
    chk("basic_sync_det", {15'd0, SYNC_DET}, 16'd1);
    chk("basic_locked", {15'd0, LOCKED}, 16'd1);
    send_word(16'h1234);
    chk("basic_pv", {15'd0, PAR_VALID}, 16'd1);
    chk("basic_par_out", PAR_OUT, 16'h1234);
    send_bit(1'b0);
    chk("basic_pv_one_cycle", {15'd0, PAR_VALID}, 16'd0);
    chk("basic_par_out_hold", PAR_OUT, 16'h1234);

    // hunt: 5 leading bits, sync, BEEF (last bit is bit 37)
    do_reset();
    pre = 5'b01101;
    for (int i = 0; i < 5; i++) send_bit(pre[i]);
    send_word(SYNC);
    chk("hunt_no_pv_before_lock", pv_cnt[15:0], 16'd0);
    chk("hunt_locked", {15'd0, LOCKED}, 16'd1);
    send_word(16'hBEEF);
    chk("hunt_pv", {15'd0, PAR_VALID}, 16'd1);
    chk("hunt_par_out", PAR_OUT, 16'hBEEF);

    // gap: sync + 9 words, 9th dropped
    do_reset();
    send_word(SYNC);
    for (int i = 1; i <= 9; i++) begin
      w = 16'(i);
      send_word(w);
    end
    chk("gap_pv_last", {15'd0, PAR_VALID}, 16'd0);
    chk("gap_pv_cnt", pv_cnt[15:0], 16'd8);
    chk("gap_par_out", PAR_OUT, 16'h0008);
    chk("gap_locked", {15'd0, LOCKED}, 16'd0);
    chk("gap_loss", {8'd0, LOSS_CNT}, 16'd1);

    // realign on last bit of a data word
    send_word(SYNC);
    chk("ra_relock", {15'd0, LOCKED}, 16'd1);
    pv_cnt = 0;
    sd_cnt = 0;
    w = 16'h5555;
    for (int i = 0; i < 15; i++) send_bit(w[i]);
    REALIGN = 1'b1;
    send_bit(w[15]);
    chk("ra_pv", {15'd0, PAR_VALID}, 16'd0);
    chk("ra_locked", {15'd0, LOCKED}, 16'd0);
    chk("ra_loss_unchanged", {8'd0, LOSS_CNT}, 16'd1);
    // REALIGN held through a full sync word keeps hunting
    send_word(SYNC);
    chk("ra_held_sd_cnt", sd_cnt[15:0], 16'd0);
    chk("ra_held_locked", {15'd0, LOCKED}, 16'd0);
    REALIGN = 1'b0;
    send_word(SYNC);
    chk("ra_release_locked", {15'd0, LOCKED}, 16'd1);
    chk("ra_release_sd_cnt", sd_cnt[15:0], 16'd1);

    // sync pattern straddling two words must be ignored while aligned
    send_word(16'h8F00);
    send_word(16'h00B3);
    chk("mid_sd_cnt", sd_cnt[15:0], 16'd1);
    chk("mid_pv_cnt", pv_cnt[15:0], 16'd2);
    chk("mid_par_out", PAR_OUT, 16'h00B3);

    // reset mid-word
    w = 16'hA5C3;
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    RESET = 1'b1;
    REALIGN = 1'b1;
    send_bit(w[8]);
    RESET = 1'b0;
    REALIGN = 1'b0;
    chk("rmw_par_out", PAR_OUT, 16'h0000);
    chk("rmw_locked", {15'd0, LOCKED}, 16'd0);
    chk("rmw_loss", {8'd0, LOSS_CNT}, 16'd0);
    chk("rmw_pv", {15'd0, PAR_VALID}, 16'd0);
    pv_cnt = 0;
    send_word(16'h1234);
    chk("rmw_needs_relock", {15'd0, LOCKED}, 16'd0);
    chk("rmw_no_pv", pv_cnt[15:0], 16'd0);

    // resync: sync, 3 words, sync, 8 words
    do_reset();
    send_word(SYNC);
    for (int i = 0; i < 3; i++) send_word(16'h1000 + 16'(i));
    send_word(SYNC);
    for (int i = 0; i < 8; i++) send_word(16'h2000 + 16'(i));
    chk("resync_pv_cnt", pv_cnt[15:0], 16'd11);
    chk("resync_sd_cnt", sd_cnt[15:0], 16'd2);
    chk("resync_locked", {15'd0, LOCKED}, 16'd1);
    chk("resync_par_out", PAR_OUT, 16'h2007);

    // saturation: 256 lock losses
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      send_word(SYNC);
      for (int i = 0; i < 9; i++) send_word(16'h0000);
      if (n == 1) chk("sat_first", {8'd0, LOSS_CNT}, 16'd1);
      if (n == 255) chk("sat_255", {8'd0, LOSS_CNT}, 16'h00FF);
    end
    chk("sat_256", {8'd0, LOSS_CNT}, 16'h00FF);
    chk("sat_locked", {15'd0, LOCKED}, 16'd0);

    chk("no_pv_sd_overlap", overlap_cnt[15:0], 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
